// File: rtl/load_pkg.sv
// Shared load/store definitions: access-size encoding, load sequencer states,
// and the width of the memory-latency down-counter.
package load_pkg;

   typedef enum logic [1:0] {
      LS_NONE = 2'b00,
      LS_WORD = 2'b01,
      LS_HALF = 2'b10,
      LS_BYTE = 2'b11
   } ls_ctrl_e;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      CAPTURE,
      DONE
   } ld_state_e;

   // Enough for MEM_LATENCY up to 15.
   localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/load_size_unit_if.sv
// Data-memory read port: the load unit drives address and strobe,
// the memory returns read data.
interface load_size_unit_if;

   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_data;

   modport master (output mem_addr, output mem_rd, input mem_data);
   modport slave  (input mem_addr, input mem_rd, output mem_data);

endinterface

// File: rtl/load_extract.sv
// Selects word/half/byte from the low lanes of the captured memory word
// and zero- or sign-extends it to 32 bits.
module load_extract
   import load_pkg::*;
(
   input  logic [31:0] mdr,
   input  ls_ctrl_e    ls_control,
   input  logic        ls_signed,
   output logic [31:0] value
);

   always_comb begin
      // NOTE: default first, so every path assigns value and no latch is inferred.
      value = mdr;
      case (ls_control)
         LS_HALF: value = {{16{ls_signed & mdr[15]}}, mdr[15:0]};
         LS_BYTE: value = {{24{ls_signed & mdr[7]}}, mdr[7:0]};
         default: value = mdr;
      endcase
   end

endmodule

// File: rtl/load_size_unit.sv
// Load sequencer: one memory read per accepted request, captures the word
// into the MDR and presents the extended result with a one-cycle done pulse.
module load_size_unit
   import load_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [1:0]               ls_control,
   input  logic                     ls_signed,
   input  logic [31:0]              addr,
   load_size_unit_if.master         mem,
   output logic                     busy,
   output logic                     done,
   output logic [31:0]              load_data,
   output logic                     align_err
);

   ld_state_e             state, next_state;
   ls_ctrl_e              req_ctrl, ctrl_q;
   logic                  signed_q;
   logic [31:0]           addr_q;
   logic [31:0]           mdr;
   logic [31:0]           load_q;
   logic [31:0]           extracted;
   logic [LAT_CNT_W-1:0]  wait_cnt;
   logic                  align_err_q;
   logic                  valid_req, misaligned, accept;

   assign req_ctrl   = ls_ctrl_e'(ls_control);
   assign misaligned = ((req_ctrl == LS_WORD) && (addr[1:0] != 2'b00)) ||
                       ((req_ctrl == LS_HALF) && addr[0]);
   assign valid_req  = (state == IDLE) && start && (req_ctrl != LS_NONE);
   assign accept     = valid_req && !misaligned;

   load_extract u_extract (
      .mdr        (mdr),
      .ls_control (ctrl_q),
      .ls_signed  (signed_q),
      .value      (extracted)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = REQ;
         REQ:     next_state = (MEM_LATENCY > 1) ? WAIT : CAPTURE;
         WAIT:    if (wait_cnt == '0) next_state = CAPTURE;
         CAPTURE: next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ctrl_q      <= LS_NONE;
         signed_q    <= 1'b0;
         addr_q      <= '0;
         mdr         <= '0;
         load_q      <= '0;
         wait_cnt    <= '0;
         align_err_q <= 1'b0;
      end else begin
         state       <= next_state;
         align_err_q <= valid_req && misaligned;
         if (accept) begin
            addr_q   <= addr;
            ctrl_q   <= req_ctrl;
            signed_q <= ls_signed;
         end
         // Loaded in REQ so WAIT lasts exactly MEM_LATENCY-1 cycles.
         if (state == REQ)
            wait_cnt <= LAT_CNT_W'(MEM_LATENCY - 2);
         else if ((state == WAIT) && (wait_cnt != '0))
            wait_cnt <= wait_cnt - 1'b1;
         if (state == CAPTURE)
            mdr <= mem.mem_data;
         if (state == DONE)
            load_q <= extracted;
      end
   end

   assign mem.mem_addr = addr_q;
   assign mem.mem_rd   = (state == REQ);
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign align_err    = align_err_q;
   // The new value must be visible in the done cycle itself.
   assign load_data    = (state == DONE) ? extracted : load_q;

endmodule

// File: tb/tb_load_size_unit.sv
// Directed bench for load_size_unit: single-latency vector table plus
// hand sequences for long latency, held start and reset mid-load.
module tb_load_size_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  ls_control;
   logic        ls_signed;
   logic [31:0] addr;

   logic        busy1, done1, err1, busy4, done4, err4;
   logic [31:0] data1, data4;

   int n_pass = 0;
   int n_total = 0;

   load_size_unit_if m1 ();
   load_size_unit_if m4 ();

   load_size_unit #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .ls_control(ls_control),
      .ls_signed(ls_signed), .addr(addr), .mem(m1.master), .busy(busy1),
      .done(done1), .load_data(data1), .align_err(err1)
   );

   load_size_unit #(.MEM_LATENCY(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .ls_control(ls_control),
      .ls_signed(ls_signed), .addr(addr), .mem(m4.master), .busy(busy4),
      .done(done4), .load_data(data4), .align_err(err4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctrl;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [31:0] exp_data;
      logic        exp_load;
      logic        exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive_req(input logic [1:0] c, input logic s, input logic [31:0] a,
                            input logic [31:0] d);
      start        = 1'b1;
      ls_control   = c;
      ls_signed    = s;
      addr         = a;
      m1.mem_data  = d;
      m4.mem_data  = d;
   endtask

   initial begin
      int rd_cnt, rd_first, done_cnt, done_first, err_cnt, err_first, both;
      logic [31:0] addr_at_rd, data_at_done;
      logic [4:0]  busy_pat;

      vecs[0] = '{2'b01, 1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[1] = '{2'b10, 1'b1, 32'h102, 32'h1234F00D, 32'hFFFFF00D, 1'b1, 1'b0};
      vecs[2] = '{2'b10, 1'b0, 32'h102, 32'h1234F00D, 32'h0000F00D, 1'b1, 1'b0};
      vecs[3] = '{2'b11, 1'b1, 32'h103, 32'hAABBCC7F, 32'h0000007F, 1'b1, 1'b0};
      vecs[4] = '{2'b11, 1'b1, 32'h101, 32'h00000080, 32'hFFFFFF80, 1'b1, 1'b0};
      vecs[5] = '{2'b01, 1'b0, 32'h101, 32'h01020304, 32'hFFFFFF80, 1'b0, 1'b1};
      vecs[6] = '{2'b10, 1'b0, 32'h103, 32'h01020304, 32'hFFFFFF80, 1'b0, 1'b1};
      vecs[7] = '{2'b00, 1'b1, 32'h104, 32'h01020304, 32'hFFFFFF80, 1'b0, 1'b0};
      vecs[8] = '{2'b11, 1'b0, 32'h000, 32'h00000080, 32'h00000080, 1'b1, 1'b0};
      vecs[9] = '{2'b01, 1'b1, 32'h200, 32'h80000001, 32'h80000001, 1'b1, 1'b0};

      reset = 1'b1; start = 1'b0; ls_control = 2'b00; ls_signed = 1'b0; addr = '0;
      m1.mem_data = '0; m4.mem_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      check("reset busy", 32'(busy1), 32'd0);
      check("reset done", 32'(done1), 32'd0);
      check("reset mem_rd", 32'(m1.mem_rd), 32'd0);
      check("reset mem_addr", m1.mem_addr, 32'd0);
      check("reset load_data", data1, 32'd0);
      check("reset align_err", 32'(err1), 32'd0);

      // Table: start presented in cycle k=0, observed in k=1..5.
      for (int v = 0; v < 10; v++) begin
         drive_req(vecs[v].ctrl, vecs[v].sgn, vecs[v].addr, vecs[v].rdata);
         rd_cnt = 0; rd_first = 0; done_cnt = 0; done_first = 0;
         err_cnt = 0; err_first = 0; both = 0; busy_pat = '0;
         addr_at_rd = '0; data_at_done = '0;
         for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (m1.mem_rd) begin
               rd_cnt++;
               if (rd_first == 0) begin rd_first = k; addr_at_rd = m1.mem_addr; end
            end
            if (done1) begin
               done_cnt++;
               if (done_first == 0) begin done_first = k; data_at_done = data1; end
            end
            if (err1) begin
               err_cnt++;
               if (err_first == 0) err_first = k;
            end
            if (done1 && err1) both++;
            busy_pat[k-1] = busy1;
            if (k == 1) begin
               start = 1'b0;
               addr = 32'hFFFF_FFFF;
               ls_control = 2'b11;
               ls_signed = ~ls_signed;
            end
         end
         check($sformatf("v%0d mem_rd count", v), 32'(rd_cnt), vecs[v].exp_load ? 32'd1 : 32'd0);
         check($sformatf("v%0d done count", v), 32'(done_cnt), vecs[v].exp_load ? 32'd1 : 32'd0);
         check($sformatf("v%0d align_err count", v), 32'(err_cnt), vecs[v].exp_err ? 32'd1 : 32'd0);
         check($sformatf("v%0d busy pattern", v), 32'(busy_pat),
               vecs[v].exp_load ? 32'b00111 : 32'b00000);
         check($sformatf("v%0d done+err overlap", v), 32'(both), 32'd0);
         check($sformatf("v%0d load_data held", v), data1, vecs[v].exp_data);
         if (vecs[v].exp_load) begin
            check($sformatf("v%0d mem_rd cycle", v), 32'(rd_first), 32'd1);
            check($sformatf("v%0d mem_addr", v), addr_at_rd, vecs[v].addr);
            check($sformatf("v%0d done cycle", v), 32'(done_first), 32'd3);
            check($sformatf("v%0d load_data at done", v), data_at_done, vecs[v].exp_data);
         end
         if (vecs[v].exp_err)
            check($sformatf("v%0d align_err cycle", v), 32'(err_first), 32'd1);
      end

      // MEM_LATENCY=4 with start held for 10 cycles.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      drive_req(2'b01, 1'b0, 32'h40, 32'h11223344);
      rd_cnt = 0; done_cnt = 0; done_first = 0; both = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k <= 7 && m4.mem_rd) rd_cnt++;
         if (k == 8) check("lat4 second mem_rd", 32'(m4.mem_rd), 32'd1);
         if (k == 7) check("lat4 idle gap busy", 32'(busy4), 32'd0);
         if (k == 6) check("lat4 load_data at done", data4, 32'h11223344);
         if (done4) begin
            done_cnt++;
            if (done_first == 0) done_first = k;
         end
         if (k == 10) start = 1'b0;
      end
      check("lat4 single mem_rd", 32'(rd_cnt), 32'd1);
      check("lat4 done cycle", 32'(done_first), 32'd6);
      check("lat4 done count", 32'(done_cnt), 32'd2);
      check("lat4 load_data final", data4, 32'h11223344);

      // Reset during WAIT aborts the load with no done pulse.
      drive_req(2'b01, 1'b0, 32'h80, 32'h55555555);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort in wait busy", 32'(busy4), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort busy", 32'(busy4), 32'd0);
      check("abort load_data", data4, 32'd0);
      check("abort mem_addr", m4.mem_addr, 32'd0);
      reset = 1'b0;
      done_cnt = 0; rd_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (done4) done_cnt++;
         if (m4.mem_rd) rd_cnt++;
         @(negedge clk);
      end
      check("abort no done", 32'(done_cnt), 32'd0);
      check("abort no mem_rd", 32'(rd_cnt), 32'd0);
      check("abort load_data stays", data4, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
